alu_operand_entry: RTL and testbench
====================================

// Module: alu_operand_entry
// PURPOSE
//  Input-side sequencer for the ALU demo board: the write end of the ALU datapath, feeding the path that ends on the 7-seg display.
//  Replaces the static switch mapping. User enters operand A, operand B and opcode one at a time on the same switches.
//  Each entry is confirmed with a debounced ENTER button; a BACK button steps back one stage.
//  Drives registered A/B/OpCode into the ALU, plus stage info for LEDs and the display mux.
// PARAMETERS
//  N                7        operand width in bits
//  DEBOUNCE_CYCLES  1000000  consecutive stable clk cycles for a button level change to count (10 ms @100 MHz)
// PORTS
//  CLK100MHZ   in   1    system clock, single clock domain
//  CPU_RESETN  in   1    asynchronous, active-low reset
//  data_in     in   N    raw operand switches (asynchronous)
//  op_in       in   2    raw opcode switches (asynchronous)
//  btn_enter   in   1    raw ENTER push-button, active-high, bouncy
//  btn_back    in   1    raw BACK push-button, active-high, bouncy
//  op_a        out  N    registered operand A to ALU
//  op_b        out  N    registered operand B to ALU
//  opcode      out  2    registered opcode to ALU
//  stage       out  2    current FSM state code, for LEDs / display select
//  result_valid out 1    high while in SHOW (ALU inputs complete and stable)
//  load_pulse  out  1    one-cycle pulse on the cycle SHOW is entered
// BEHAVIOUR
//  Reset (async assert, sync-free deassert)
//   - op_a=0, op_b=0, opcode=0, stage=ENTER_A, result_valid=0, load_pulse=0.
//   - Synchronizers clear to 0; debounce counters clear to 0; debounced button levels clear to 0.
//  Input synchronisation
//   - data_in, op_in, btn_enter and btn_back each pass through a 2-flop synchronizer.
//   - Every capture uses the synchronized value.
//  Debounce, per button
//   - Stable level register L, counter C.
//   - Sync input != L: C increments each cycle. Sync input == L: C is reset to 0.
//   - When C reaches DEBOUNCE_CYCLES-1 while still differing: L toggles and C clears.
//   - A press pulse (1 cycle) fires on the 0->1 toggle of L only.
//   - A held button gives exactly one pulse. The next pulse requires a debounced release first.
//   - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
//  FSM states (stage code): ENTER_A=0, ENTER_B=1, ENTER_OP=2, SHOW=3
//   - ENTER_A  + enter pulse: op_a <= data_sync;  go to ENTER_B.
//   - ENTER_B  + enter pulse: op_b <= data_sync;  go to ENTER_OP.
//   - ENTER_OP + enter pulse: opcode <= op_sync;  go to SHOW; load_pulse=1 for that one cycle.
//   - SHOW     + enter pulse: go to ENTER_A. op_a/op_b/opcode hold their values until overwritten.
//   - Back pulse: ENTER_B->ENTER_A, ENTER_OP->ENTER_B, SHOW->ENTER_OP. Ignored in ENTER_A.
//   - Back never modifies any captured register.
//   - Enter and back pulses in the same cycle: enter wins, back is discarded.
//   - Capture and state change occur on the same clock edge as the pulse cycle. Outputs update the following cycle.
//   - result_valid = (stage==SHOW), registered. It drops the cycle after leaving SHOW.
//  Latency
//   - From a clean button edge to the stage change: 2 (sync) + DEBOUNCE_CYCLES + 1 clk cycles.
//  Reset mid-operation
//   - Any state returns to ENTER_A with all registers cleared, including a press partly debounced.
//   - A button held through reset release yields one pulse once the debounce completes.
// TESTING  (DEBOUNCE_CYCLES=4 in sim)
//  1. Reset; data_in=7'h15, clean ENTER; data_in=7'h0A, ENTER; op_in=2'b10, ENTER
//     -> op_a=15, op_b=0A, opcode=2, stage=3, result_valid=1, single load_pulse.
//  2. ENTER bouncing 1-0-1 with 2-cycle gaps, then stable 10 cycles -> exactly one stage advance.
//  3. ENTER held 50 cycles -> one advance only. Release >=4 cycles, press again -> second advance.
//  4. In ENTER_OP (A=15, B=0A), BACK -> stage=1 with op_b still 0A. ENTER with data_in=7'h03 -> op_b=03, stage=2.
//  5. In ENTER_B, ENTER and BACK debounce-complete in the same cycle -> stage=2, op_b captured.
//  6. In SHOW, assert CPU_RESETN=0 asynchronously mid-cycle -> immediately op_a=op_b=opcode=0, stage=0, result_valid=0.

Source files
------------

// File: rtl/alu_operand_entry.sv
// ============================================================================
// alu_operand_entry
//
// Input-side sequencer for the ALU demo board. The user enters operand A,
// operand B and the opcode one at a time on the same switches. Each entry is
// confirmed with a debounced ENTER button. A debounced BACK button steps back
// one stage. The captured values drive the ALU; stage information drives the
// LEDs and the display mux.
//
// Parameters
//   N                operand width in bits
//   DEBOUNCE_CYCLES  consecutive stable clocks before a button level change
//                    is accepted
//
// Ports
//   CLK100MHZ     in   system clock (only clock domain)
//   CPU_RESETN    in   asynchronous active-low reset
//   data_in       in   raw operand switches (asynchronous)
//   op_in         in   raw opcode switches (asynchronous)
//   btn_enter     in   raw ENTER button, active-high, bouncy
//   btn_back      in   raw BACK button, active-high, bouncy
//   op_a          out  registered operand A
//   op_b          out  registered operand B
//   opcode        out  registered opcode
//   stage         out  current state code (0=A, 1=B, 2=OP, 3=SHOW)
//   result_valid  out  high while in SHOW
//   load_pulse    out  one-cycle pulse in the first cycle of SHOW
// ============================================================================
module alu_operand_entry #(
    parameter int N               = 7,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic         CLK100MHZ,
    input  logic         CPU_RESETN,
    input  logic [N-1:0] data_in,
    input  logic [1:0]   op_in,
    input  logic         btn_enter,
    input  logic         btn_back,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [1:0]   opcode,
    output logic [1:0]   stage,
    output logic         result_valid,
    output logic         load_pulse
);

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'd0,
        ST_ENTER_B  = 2'd1,
        ST_ENTER_OP = 2'd2,
        ST_SHOW     = 2'd3
    } state_t;

    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers. Button bit 0 = ENTER, bit 1 = BACK.
    // ------------------------------------------------------------------
    logic [N-1:0] data_meta_q, data_sync_q;
    logic [1:0]   op_meta_q,   op_sync_q;
    logic [1:0]   btn_meta_q,  btn_sync_q;
    logic [1:0]   btn_raw;

    assign btn_raw = {btn_back, btn_enter};

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            data_meta_q <= '0;
            data_sync_q <= '0;
            op_meta_q   <= '0;
            op_sync_q   <= '0;
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
        end else begin
            data_meta_q <= data_in;
            data_sync_q <= data_meta_q;
            op_meta_q   <= op_in;
            op_sync_q   <= op_meta_q;
            btn_meta_q  <= btn_raw;
            btn_sync_q  <= btn_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce, one instance per button. The press pulse is registered,
    // so the FSM acts one cycle after the debounced level rises.
    // ------------------------------------------------------------------
    logic [1:0] btn_press;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          level_q, level_d;
            logic          press_q, press_d;
            logic [CW-1:0] cnt_q,   cnt_d;

            always_comb begin
                level_d = level_q;
                press_d = 1'b0;
                cnt_d   = '0;
                if (btn_sync_q[gi] != level_q) begin
                    if (cnt_q == CNT_MAX) begin
                        level_d = ~level_q;
                        // Pulse only on the rising toggle of the stable level.
                        press_d = ~level_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
                if (!CPU_RESETN) begin
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    level_q <= level_d;
                    press_q <= press_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign btn_press[gi] = press_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Entry sequencer
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [N-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]   opcode_q, opcode_d;
    logic         valid_q, valid_d;
    logic         load_q, load_d;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        load_d   = 1'b0;
        // ENTER has priority; a simultaneous BACK is dropped.
        if (btn_press[0]) begin
            case (state_q)
                ST_ENTER_A: begin
                    op_a_d  = data_sync_q;
                    state_d = ST_ENTER_B;
                end
                ST_ENTER_B: begin
                    op_b_d  = data_sync_q;
                    state_d = ST_ENTER_OP;
                end
                ST_ENTER_OP: begin
                    opcode_d = op_sync_q;
                    state_d  = ST_SHOW;
                    load_d   = 1'b1;
                end
                default: state_d = ST_ENTER_A;
            endcase
        end else if (btn_press[1]) begin
            case (state_q)
                ST_ENTER_B:  state_d = ST_ENTER_A;
                ST_ENTER_OP: state_d = ST_ENTER_B;
                ST_SHOW:     state_d = ST_ENTER_OP;
                default:     state_d = ST_ENTER_A;
            endcase
        end
        // Derived from the next state so it tracks stage exactly.
        valid_d = (state_d == ST_SHOW);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q  <= ST_ENTER_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            valid_q  <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
            load_q   <= load_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign opcode       = opcode_q;
    assign stage        = state_q;
    assign result_valid = valid_q;
    assign load_pulse   = load_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// ============================================================================
// tb_alu_operand_entry
//
// Directed bench for alu_operand_entry with DEBOUNCE_CYCLES=4. Inputs are
// driven on the falling edge, outputs are sampled on the falling edge.
// ============================================================================
module tb_alu_operand_entry;

    localparam int N  = 7;
    localparam int DB = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic [1:0]   op_in;
    logic         btn_enter;
    logic         btn_back;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [1:0]   opcode;
    logic [1:0]   stage;
    logic         result_valid;
    logic         load_pulse;

    int vectors     = 0;
    int miscompares = 0;
    int changes     = 0;
    int lp_cnt      = 0;
    logic [1:0] prev_stage;

    alu_operand_entry #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .data_in     (data_in),
        .op_in       (op_in),
        .btn_enter   (btn_enter),
        .btn_back    (btn_back),
        .op_a        (op_a),
        .op_b        (op_b),
        .opcode      (opcode),
        .stage       (stage),
        .result_valid(result_valid),
        .load_pulse  (load_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, counting stage changes and load pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stage !== prev_stage) changes++;
            prev_stage = stage;
            if (load_pulse === 1'b1) lp_cnt++;
        end
    endtask

    task automatic clr();
        changes    = 0;
        lp_cnt     = 0;
        prev_stage = stage;
    endtask

    task automatic press_enter(input logic [N-1:0] d, input logic [1:0] o);
        data_in   = d;
        op_in     = o;
        btn_enter = 1'b1;
        run(12);
        btn_enter = 1'b0;
        run(10);
        $display("enter data=%h op=%0d -> stage=%0d a=%h b=%h opc=%0d", d, o, stage, op_a, op_b, opcode);
    endtask

    task automatic press_back();
        btn_back = 1'b1;
        run(12);
        btn_back = 1'b0;
        run(10);
        $display("back -> stage=%0d a=%h b=%h opc=%0d", stage, op_a, op_b, opcode);
    endtask

    initial begin
        rst_n     = 1'b0;
        data_in   = '0;
        op_in     = '0;
        btn_enter = 1'b0;
        btn_back  = 1'b0;
        prev_stage = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_stage", stage, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_load", load_pulse, 0);

        // 1. A=15, B=0A, op=2, with exact latency check on the first press
        clr();
        data_in   = 7'h15;
        btn_enter = 1'b1;
        run(2 + DB);
        chk("lat_before", stage, 0);
        run(1);
        chk("lat_at", stage, 1);
        chk("t1_op_a", op_a, 7'h15);
        run(3);
        btn_enter = 1'b0;
        run(10);
        $display("enter data=15 -> stage=%0d a=%h", stage, op_a);
        press_enter(7'h0A, 2'b00);
        chk("t1_stage_op", stage, 2);
        chk("t1_op_b", op_b, 7'h0A);
        chk("t1_valid_low", result_valid, 0);
        clr();
        press_enter(7'h7F, 2'b10);
        chk("t1_op_a_final", op_a, 7'h15);
        chk("t1_op_b_final", op_b, 7'h0A);
        chk("t1_opcode", opcode, 2);
        chk("t1_stage_show", stage, 3);
        chk("t1_valid", result_valid, 1);
        chk("t1_load_count", lp_cnt, 1);

        // 2. Bouncing ENTER in SHOW -> one advance to ENTER_A
        clr();
        btn_enter = 1'b1; run(2);
        btn_enter = 1'b0; run(2);
        btn_enter = 1'b1; run(2);
        btn_enter = 1'b0; run(2);
        btn_enter = 1'b1; run(10);
        btn_enter = 1'b0; run(10);
        $display("bounce -> stage=%0d changes=%0d", stage, changes);
        chk("t2_changes", changes, 1);
        chk("t2_stage", stage, 0);
        chk("t2_valid", result_valid, 0);
        chk("t2_op_a_held", op_a, 7'h15);

        // 3. Held ENTER gives one advance; a short release re-arms it
        clr();
        data_in   = 7'h15;
        btn_enter = 1'b1;
        run(50);
        $display("hold 50 -> stage=%0d changes=%0d", stage, changes);
        chk("t3_hold_changes", changes, 1);
        chk("t3_hold_stage", stage, 1);
        data_in   = 7'h0A;
        btn_enter = 1'b0;
        run(DB);
        btn_enter = 1'b1;
        run(12);
        btn_enter = 1'b0;
        run(10);
        $display("re-press -> stage=%0d changes=%0d b=%h", stage, changes, op_b);
        chk("t3_second_changes", changes, 2);
        chk("t3_stage", stage, 2);
        chk("t3_op_b", op_b, 7'h0A);

        // 4. BACK from ENTER_OP keeps op_b, then re-enter B
        press_back();
        chk("t4_back_stage", stage, 1);
        chk("t4_op_b_kept", op_b, 7'h0A);
        chk("t4_op_a_kept", op_a, 7'h15);
        press_enter(7'h03, 2'b00);
        chk("t4_op_b_new", op_b, 7'h03);
        chk("t4_stage", stage, 2);

        // 5. In ENTER_B, simultaneous ENTER and BACK: ENTER wins
        press_back();
        chk("t5_pre_stage", stage, 1);
        clr();
        data_in   = 7'h55;
        btn_enter = 1'b1;
        btn_back  = 1'b1;
        run(12);
        btn_enter = 1'b0;
        btn_back  = 1'b0;
        run(10);
        $display("enter+back -> stage=%0d b=%h changes=%0d", stage, op_b, changes);
        chk("t5_stage", stage, 2);
        chk("t5_op_b", op_b, 7'h55);
        chk("t5_changes", changes, 1);

        // 6. Async reset from SHOW
        press_enter(7'h00, 2'b01);
        chk("t6_show", stage, 3);
        chk("t6_opcode", opcode, 1);
        #2;
        rst_n     = 1'b0;
        btn_enter = 1'b1;
        #1;
        $display("async reset -> stage=%0d a=%h b=%h opc=%0d", stage, op_a, op_b, opcode);
        chk("t6_op_a", op_a, 0);
        chk("t6_op_b", op_b, 0);
        chk("t6_opcode_rst", opcode, 0);
        chk("t6_stage_rst", stage, 0);
        chk("t6_valid_rst", result_valid, 0);

        // Button held through reset release: one capture after debounce
        @(negedge clk);
        @(negedge clk);
        data_in = 7'h2C;
        rst_n   = 1'b1;
        clr();
        run(20);
        btn_enter = 1'b0;
        run(10);
        $display("held through reset -> stage=%0d a=%h changes=%0d", stage, op_a, changes);
        chk("t6_held_changes", changes, 1);
        chk("t6_held_stage", stage, 1);
        chk("t6_held_op_a", op_a, 7'h2C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
